// File: rtl/accel_spi_pkg.sv
// rtl/accel_spi_pkg.sv - shared types and constants for the accelerometer SPI reader
package accel_spi_pkg;

    typedef enum logic [1:0] {
        ST_INIT_FMT,
        ST_INIT_PWR,
        ST_WAIT,
        ST_READ
    } accel_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_LOW,
        PH_HIGH,
        PH_HOLD,
        PH_GUARD
    } spi_phase_t;

    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [7:0] DATA_FORMAT_VAL = 8'h0B;
    localparam logic [7:0] POWER_CTL_VAL   = 8'h08;
    localparam logic [4:0] WR_FRAME_BITS   = 5'd16;
    localparam logic [4:0] RD_FRAME_BITS   = 5'd24;

    // Frames are left-aligned in the 24-bit tx word; the engine always shifts out bit 23 first.
    function automatic logic [23:0] write_word(input logic [5:0] addr, input logic [7:0] data);
        return {2'b00, addr, data, 8'h00};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - mode-3 SPI frame engine: CS/SCLK/MOSI timing and MISO capture
module spi_shift_engine
    import accel_spi_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  nbits,
    input  logic [23:0] tx,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        done,
    output logic        busy,
    output logic [23:0] rx
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(2 * CLK_DIV - 3);

    spi_phase_t     r_phase;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_bit;
    logic [4:0]     r_nbits;
    logic [23:0]    r_tx;
    logic [23:0]    r_rx;
    logic           r_cs_n;
    logic           r_sclk;
    logic           r_mosi;
    logic           r_done;

    assign spi_cs_n = r_cs_n;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign done     = r_done;
    assign rx       = r_rx;
    assign busy     = (r_phase != PH_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset lands in the guard phase so CS stays high long enough even after an aborted frame.
            r_phase <= PH_GUARD;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_nbits <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        r_cs_n  <= 1'b0;
                        r_tx    <= tx;
                        r_mosi  <= tx[23];
                        r_nbits <= nbits;
                        r_bit   <= '0;
                        r_rx    <= '0;
                        r_cnt   <= '0;
                        r_phase <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b0;
                        r_phase <= PH_LOW;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PH_LOW: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx    <= {r_rx[22:0], spi_miso};
                        r_phase <= PH_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PH_HIGH: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == r_nbits - 5'd1) begin
                            r_phase <= PH_HOLD;
                        end else begin
                            r_bit   <= r_bit + 5'd1;
                            r_sclk  <= 1'b0;
                            r_tx    <= {r_tx[22:0], 1'b0};
                            r_mosi  <= r_tx[22];
                            r_phase <= PH_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PH_HOLD: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_phase <= PH_GUARD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PH_GUARD: begin
                    // Two more cycles of start latency in the caller make the CS-high gap exactly 2*CLK_DIV.
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt   <= '0;
                        r_phase <= PH_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_phase <= PH_GUARD;
            endcase
        end
    end

endmodule

// File: rtl/accel_spi_reader.sv
// rtl/accel_spi_reader.sv - accelerometer init and periodic axis read over SPI
module accel_spi_reader
    import accel_spi_pkg::*;
#(
    parameter int         CLK_DIV       = 25,
    parameter int         SAMPLE_PERIOD = 50000,
    parameter logic [5:0] AXIS_ADDR     = 6'h32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        init_done
);

    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

    accel_state_t   r_state;
    logic           r_start;
    logic           r_sent;
    logic [23:0]    r_tx;
    logic [4:0]     r_nbits;
    logic [TW-1:0]  r_timer;
    logic [15:0]    r_data;
    logic           r_valid;
    logic           r_init_done;

    logic           w_done;
    logic           w_busy;
    logic [23:0]    w_rx;
    logic           w_unused_rx;

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign init_done   = r_init_done;
    assign w_unused_rx = ^w_rx[23:16];

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk      (clk),
        .rst      (rst),
        .start    (r_start),
        .nbits    (r_nbits),
        .tx       (r_tx),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .done     (w_done),
        .busy     (w_busy),
        .rx       (w_rx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_INIT_FMT;
            r_start     <= 1'b0;
            r_sent      <= 1'b0;
            r_tx        <= '0;
            r_nbits     <= '0;
            r_timer     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            if (r_timer != TIMER_LAST) begin
                r_timer <= r_timer + TW'(1);
            end
            case (r_state)
                ST_INIT_FMT: begin
                    if (!r_sent && !w_busy) begin
                        r_start <= 1'b1;
                        r_sent  <= 1'b1;
                        r_tx    <= write_word(REG_DATA_FORMAT, DATA_FORMAT_VAL);
                        r_nbits <= WR_FRAME_BITS;
                    end else if (w_done) begin
                        r_sent  <= 1'b0;
                        r_state <= ST_INIT_PWR;
                    end
                end
                ST_INIT_PWR: begin
                    if (!r_sent && !w_busy) begin
                        r_start <= 1'b1;
                        r_sent  <= 1'b1;
                        r_tx    <= write_word(REG_POWER_CTL, POWER_CTL_VAL);
                        r_nbits <= WR_FRAME_BITS;
                    end else if (w_done) begin
                        r_sent      <= 1'b0;
                        r_state     <= ST_WAIT;
                        r_init_done <= 1'b1;
                        // Preloading as expired makes the first read go out without waiting a period.
                        r_timer     <= TIMER_LAST;
                    end
                end
                ST_WAIT: begin
                    if (r_timer == TIMER_LAST && !w_busy) begin
                        r_start <= 1'b1;
                        r_tx    <= {2'b11, AXIS_ADDR, 16'h0000};
                        r_nbits <= RD_FRAME_BITS;
                        r_timer <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_done) begin
                        r_data  <= {w_rx[7:0], w_rx[15:8]};
                        r_valid <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                default: r_state <= ST_INIT_FMT;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// tb/tb_accel_spi_reader.sv - directed bench with mode-3 slave models and protocol checker
module tb_accel_spi_reader;

    localparam int D  = 2;
    localparam int NF = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs_n, sclk, mosi, dv, idone;
    logic [1:0]  miso = 2'b00;
    logic [15:0] dout_a, dout_b;

    always #5 clk = ~clk;

    accel_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(400), .AXIS_ADDR(6'h32)) dut_a (
        .clk(clk), .rst(rst), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .data_out(dout_a), .data_valid(dv[0]), .init_done(idone[0]));

    accel_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(10), .AXIS_ADDR(6'h32)) dut_b (
        .clk(clk), .rst(rst), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .data_out(dout_b), .data_valid(dv[1]), .init_done(idone[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [23:0] slv_word [2];
    logic [23:0] sh [2];
    logic [23:0] rxsh [2];
    int          bitcnt [2];
    int          lowcnt [2];
    int          high_run [2];
    int          prot_err [2];
    int          fr_count [2];
    int          fr_bits [2][NF];
    int          fr_low [2][NF];
    int          fall_cyc [2][NF];
    int          rise_cyc [2][NF];
    logic [23:0] fr_data [2][NF];
    int          dv_count [2];
    int          dv_cyc [2][NF];
    logic [15:0] dv_data [2][NF];
    int          idone_cyc [2];
    logic [1:0]  p_cs, p_sclk, p_mosi, p_idone;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic prot_fail(input int g, input string what);
        prot_err[g]++;
        if (prot_err[g] <= 5)
            $display("FAIL protocol dut%0d %s at cycle %0d: violation observed, required none", g, what, cyc);
    endtask

    // Slave: shifts its word out on SCLK fall, captures MOSI on SCLK rise; also logs frames and strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                if (cs_n[g] && !sclk[g]) prot_fail(g, "sclk_low_with_cs_high");
                if (!cs_n[g] && !p_cs[g] && sclk[g] && p_sclk[g] && mosi[g] !== p_mosi[g])
                    prot_fail(g, "mosi_changed_while_sclk_high");
                if (p_cs[g] && !cs_n[g]) begin
                    if (high_run[g] < 2 * D) prot_fail(g, "short_cs_gap");
                    high_run[g] = 0;
                    bitcnt[g] = 0;
                    rxsh[g] = '0;
                    sh[g] = slv_word[g];
                    lowcnt[g] = 1;
                    if (fr_count[g] < NF) fall_cyc[g][fr_count[g]] = cyc;
                end else if (!cs_n[g]) begin
                    lowcnt[g]++;
                end
                if (cs_n[g]) high_run[g]++;
                if (!cs_n[g] && p_sclk[g] && !sclk[g]) begin
                    miso[g] = sh[g][23];
                    sh[g] = {sh[g][22:0], 1'b0};
                end
                if (!cs_n[g] && !p_sclk[g] && sclk[g]) begin
                    rxsh[g] = {rxsh[g][22:0], mosi[g]};
                    bitcnt[g]++;
                end
                if (!p_cs[g] && cs_n[g] && fr_count[g] < NF) begin
                    fr_bits[g][fr_count[g]] = bitcnt[g];
                    fr_data[g][fr_count[g]] = rxsh[g];
                    fr_low[g][fr_count[g]] = lowcnt[g];
                    rise_cyc[g][fr_count[g]] = cyc;
                    fr_count[g]++;
                end
                if (dv[g] && dv_count[g] < NF) begin
                    dv_cyc[g][dv_count[g]] = cyc;
                    dv_data[g][dv_count[g]] = (g == 0) ? dout_a : dout_b;
                    dv_count[g]++;
                end
                if (idone[g] && !p_idone[g]) idone_cyc[g] = cyc;
            end
        end
        p_cs = cs_n;
        p_sclk = sclk;
        p_mosi = mosi;
        p_idone = idone;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (cs_n[0] !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", cs_n[0]); end
        checks++; if (sclk[0] !== 1'b1) begin failures++; $display("FAIL reset_sclk: got %b want 1", sclk[0]); end
        checks++; if (mosi[0] !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", mosi[0]); end
        checks++; if (dout_a !== 16'h0000) begin failures++; $display("FAIL reset_data_out: got %h want 0000", dout_a); end
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL reset_data_valid: got %b want 0", dv[0]); end
        checks++; if (idone[0] !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b want 0", idone[0]); end
        checks++; if (cs_n[1] !== 1'b1 || sclk[1] !== 1'b1) begin failures++; $display("FAIL reset_b_cs_sclk: got %b%b want 11", cs_n[1], sclk[1]); end
        mon_en = 1'b1;
        rst = 1'b1;
    endtask

    task automatic test_init();
        int n;
        n = 0;
        while (fr_count[0] < 1 && n < 500) begin step(); n++; end
        checks++; if (idone[0] !== 1'b0) begin failures++; $display("FAIL init_done_early: got %b want 0", idone[0]); end
        while (fr_count[0] < 2 && n < 500) begin step(); n++; end
        repeat (3) step();
        checks++; if (fr_count[0] < 2) begin failures++; $display("FAIL init_frames_timeout: got %0d frames want 2", fr_count[0]); end
        checks++; if (fr_bits[0][0] !== 16) begin failures++; $display("FAIL init_fmt_bits: got %0d want 16", fr_bits[0][0]); end
        checks++; if (fr_data[0][0] !== 24'h00310B) begin failures++; $display("FAIL init_fmt_mosi: got %h want 00310b", fr_data[0][0]); end
        checks++; if (fr_low[0][0] !== 34 * D) begin failures++; $display("FAIL init_fmt_len: got %0d want %0d", fr_low[0][0], 34 * D); end
        checks++; if (fr_bits[0][1] !== 16) begin failures++; $display("FAIL init_pwr_bits: got %0d want 16", fr_bits[0][1]); end
        checks++; if (fr_data[0][1] !== 24'h002D08) begin failures++; $display("FAIL init_pwr_mosi: got %h want 002d08", fr_data[0][1]); end
        checks++; if (fall_cyc[0][1] - rise_cyc[0][0] !== 2 * D) begin failures++; $display("FAIL init_gap: got %0d want %0d", fall_cyc[0][1] - rise_cyc[0][0], 2 * D); end
        checks++; if (idone[0] !== 1'b1 || idone_cyc[0] - rise_cyc[0][1] !== 1) begin failures++; $display("FAIL init_done_rise: got level %b delay %0d want 1 delay 1", idone[0], idone_cyc[0] - rise_cyc[0][1]); end
    endtask

    task automatic test_read();
        int n;
        n = 0;
        while (dv_count[0] < 1 && n < 500) begin step(); n++; end
        checks++; if (dv_count[0] < 1) begin failures++; $display("FAIL read_timeout: got %0d strobes want 1", dv_count[0]); end
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL read_valid_width: got %b one cycle later want 0", dv[0]); end
        checks++; if (fr_bits[0][2] !== 24) begin failures++; $display("FAIL read_bits: got %0d want 24", fr_bits[0][2]); end
        checks++; if (fr_data[0][2][23:16] !== 8'hF2) begin failures++; $display("FAIL read_cmd_byte: got %h want f2", fr_data[0][2][23:16]); end
        checks++; if (fr_data[0][2][15:0] !== 16'h0000) begin failures++; $display("FAIL read_mosi_tail: got %h want 0000", fr_data[0][2][15:0]); end
        checks++; if (fr_low[0][2] !== 50 * D) begin failures++; $display("FAIL read_len: got %0d want %0d", fr_low[0][2], 50 * D); end
        checks++; if (fall_cyc[0][2] - rise_cyc[0][1] !== 2 * D) begin failures++; $display("FAIL first_read_gap: got %0d want %0d", fall_cyc[0][2] - rise_cyc[0][1], 2 * D); end
        checks++; if (dv_data[0][0] !== 16'hFF34) begin failures++; $display("FAIL read_data: got %h want ff34", dv_data[0][0]); end
        checks++; if (dv_cyc[0][0] - rise_cyc[0][2] !== 1) begin failures++; $display("FAIL read_valid_delay: got %0d want 1", dv_cyc[0][0] - rise_cyc[0][2]); end
        repeat (10) step();
        checks++; if (dout_a !== 16'hFF34) begin failures++; $display("FAIL read_data_hold: got %h want ff34", dout_a); end
    endtask

    task automatic test_period();
        int n;
        n = 0;
        while (fr_count[0] < 5 && n < 1500) begin step(); n++; end
        checks++; if (fr_count[0] < 5) begin failures++; $display("FAIL period_timeout: got %0d frames want 5", fr_count[0]); end
        checks++; if (fall_cyc[0][3] - fall_cyc[0][2] !== 400) begin failures++; $display("FAIL period_1: got %0d want 400", fall_cyc[0][3] - fall_cyc[0][2]); end
        checks++; if (fall_cyc[0][4] - fall_cyc[0][3] !== 400) begin failures++; $display("FAIL period_2: got %0d want 400", fall_cyc[0][4] - fall_cyc[0][3]); end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        while ((fr_count[1] < 6 || dv_count[1] < 2) && n < 1500) begin step(); n++; end
        checks++; if (fr_count[1] < 6 || dv_count[1] < 2) begin failures++; $display("FAIL b2b_timeout: got %0d frames %0d strobes want 6 and 2", fr_count[1], dv_count[1]); end
        checks++; if (fall_cyc[1][3] - rise_cyc[1][2] !== 2 * D) begin failures++; $display("FAIL b2b_gap_1: got %0d want %0d", fall_cyc[1][3] - rise_cyc[1][2], 2 * D); end
        checks++; if (fall_cyc[1][4] - rise_cyc[1][3] !== 2 * D) begin failures++; $display("FAIL b2b_gap_2: got %0d want %0d", fall_cyc[1][4] - rise_cyc[1][3], 2 * D); end
        checks++; if (fall_cyc[1][4] - fall_cyc[1][3] !== 52 * D) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", fall_cyc[1][4] - fall_cyc[1][3], 52 * D); end
        checks++; if (dv_data[1][0] !== 16'h7F80) begin failures++; $display("FAIL b2b_data: got %h want 7f80", dv_data[1][0]); end
    endtask

    task automatic test_mid_reset();
        int n;
        int base_fr;
        int base_dv;
        n = 0;
        while (!(cs_n[0] === 1'b0 && fr_count[0] >= 5) && n < 1000) begin step(); n++; end
        checks++; if (n >= 1000) begin failures++; $display("FAIL mid_reset_wait: got no read frame want one"); end
        repeat (30) step();
        base_dv = dv_count[0];
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b1) begin failures++; $display("FAIL mid_reset_cs_sclk: got %b%b want 11", cs_n[0], sclk[0]); end
        checks++; if (dout_a !== 16'h0000) begin failures++; $display("FAIL mid_reset_data: got %h want 0000", dout_a); end
        checks++; if (idone[0] !== 1'b0) begin failures++; $display("FAIL mid_reset_init_done: got %b want 0", idone[0]); end
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", dv[0]); end
        step();
        base_fr = fr_count[0];
        n = 0;
        while (fr_count[0] < base_fr + 2 && n < 500) begin step(); n++; end
        repeat (2) step();
        checks++; if (fr_data[0][base_fr] !== 24'h00310B) begin failures++; $display("FAIL reinit_fmt: got %h want 00310b", fr_data[0][base_fr]); end
        checks++; if (fr_data[0][base_fr + 1] !== 24'h002D08) begin failures++; $display("FAIL reinit_pwr: got %h want 002d08", fr_data[0][base_fr + 1]); end
        checks++; if (dv_count[0] !== base_dv) begin failures++; $display("FAIL aborted_valid: got %0d strobes want %0d", dv_count[0], base_dv); end
        n = 0;
        while (dv_count[0] <= base_dv && n < 500) begin step(); n++; end
        checks++; if (dv_data[0][base_dv] !== 16'hFF34) begin failures++; $display("FAIL reread_data: got %h want ff34", dv_data[0][base_dv]); end
        checks++; if (dv_cyc[0][base_dv] - rise_cyc[0][base_fr + 2] !== 1) begin failures++; $display("FAIL reread_delay: got %0d want 1", dv_cyc[0][base_dv] - rise_cyc[0][base_fr + 2]); end
    endtask

    task automatic test_protocol();
        checks++; if (prot_err[0] !== 0) begin failures++; $display("FAIL protocol_a: got %0d violations want 0", prot_err[0]); end
        checks++; if (prot_err[1] !== 0) begin failures++; $display("FAIL protocol_b: got %0d violations want 0", prot_err[1]); end
    endtask

    initial begin
        slv_word[0] = {8'h00, 8'h34, 8'hFF};
        slv_word[1] = {8'h00, 8'h80, 8'h7F};
        for (int g = 0; g < 2; g++) begin
            sh[g] = '0;
            rxsh[g] = '0;
            bitcnt[g] = 0;
            lowcnt[g] = 0;
            high_run[g] = 1000;
            prot_err[g] = 0;
            fr_count[g] = 0;
            dv_count[g] = 0;
            idone_cyc[g] = 0;
        end
        test_reset();
        test_init();
        test_read();
        test_period();
        test_back_to_back();
        test_mid_reset();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
